// File: rtl/raw_stream_prefetch.sv
// rtl/raw_stream_prefetch.sv - MCB read prefetch FIFO feeding the raw-data byte streamer
module raw_stream_prefetch #(
  parameter int AXNUM = 24,
  parameter int ABITS = 21,
  parameter int DLOG  = 2,
  parameter int DELAY = 3
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [ABITS-1:0] wr_adr_i,
  input  logic             mcb_rdy_i,
  output logic             mcb_req_o,
  output logic [ABITS-1:0] mcb_adr_o,
  input  logic             mcb_ack_i,
  input  logic [31:0]      mcb_dat_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [AXNUM-1:0] dat_o,
  output logic [DLOG:0]    level_o,
  output logic [1:0]       err_o,
  output logic [1:0]       state_o
);

  localparam int DEPTH = 2**DLOG;
  localparam logic [DLOG:0] DEPTH_L = (DLOG+1)'(DEPTH);
  // Register delay only matters to behavioural models of this block.
  localparam int unused_delay = DELAY;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [ABITS-1:0] rd_adr;
  logic [DLOG:0]    outstanding;
  logic [DLOG:0]    level;
  logic [DLOG-1:0]  wr_ptr;
  logic [DLOG-1:0]  rd_ptr;
  logic [AXNUM-1:0] mem [DEPTH];

  logic issue;
  logic ack_take;
  logic ack_write;
  logic stray_ack;
  logic pop_take;
  logic underrun;
  logic to_idle;
  logic unused_dat;

  assign unused_dat = ^mcb_dat_i[31:AXNUM];

  // Requests stop as soon as enable drops, so nothing new is in flight once
  // the FSM decides between DRAIN and IDLE.
  assign issue = (state == ST_RUN) && enable_i && mcb_rdy_i
              && (({1'b0, level} + {1'b0, outstanding}) < {1'b0, DEPTH_L})
              && (rd_adr != wr_adr_i);

  assign ack_take  = mcb_ack_i && (outstanding != '0);
  assign ack_write = ack_take && (state == ST_RUN);
  assign stray_ack = mcb_ack_i && (outstanding == '0);
  assign pop_take  = pop_i && (level != '0);
  assign underrun  = pop_i && (level == '0);
  assign to_idle   = ((state == ST_RUN) && !enable_i && (outstanding == '0))
                  || ((state == ST_DRAIN) && (outstanding == '0));

  assign valid_o = (level != '0);
  assign dat_o   = mem[rd_ptr];
  assign level_o = level;
  assign state_o = state;

  // Control FSM: RUN while streaming, DRAIN to swallow in-flight reads after disable.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (enable_i) state <= ST_RUN;
        ST_RUN:   if (!enable_i) state <= (outstanding != '0) ? ST_DRAIN : ST_IDLE;
        ST_DRAIN: if (outstanding == '0) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Read request strobe, sequential read address and in-flight credit count.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mcb_req_o   <= 1'b0;
      mcb_adr_o   <= '0;
      rd_adr      <= '0;
      outstanding <= '0;
    end else begin
      mcb_req_o <= issue;
      if (issue) begin
        mcb_adr_o <= rd_adr;
        rd_adr    <= rd_adr + 1'b1;
      end
      case ({issue, ack_take})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FWFT storage: head word is always mem[rd_ptr]; flushed on every return to IDLE.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (to_idle) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (ack_write) begin
        mem[wr_ptr] <= mcb_dat_i[AXNUM-1:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_take) rd_ptr <= rd_ptr + 1'b1;
      case ({ack_write, pop_take})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags; a fresh event wins over a coincident clear.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      err_o <= 2'b00;
    end else begin
      err_o[0] <= underrun  | (err_o[0] & ~clear_i);
      err_o[1] <= stray_ack | (err_o[1] & ~clear_i);
    end
  end

  // An ack landing in a full FIFO means the credit accounting broke.
  assert property (@(posedge clock_i) disable iff (!reset_ni)
                   !(ack_write && (level == DEPTH_L)));

endmodule

// File: tb/tb_raw_stream_prefetch.sv
// tb/tb_raw_stream_prefetch.sv - self-checking bench for raw_stream_prefetch
module tb_raw_stream_prefetch;
  localparam int AX = 24;
  localparam int AB = 21;
  localparam int DL = 2;
  localparam int DEPTH = 4;

  typedef struct {
    int          due;
    logic [31:0] d;
  } pend_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- main instance ----------------
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          rdy = 1'b0;
  logic          pop = 1'b0;
  logic [AB-1:0] wr_adr = '0;
  logic          r_ack = 1'b0;
  logic          inj_ack = 1'b0;
  logic [31:0]   r_dat = '0;
  logic          mcb_ack;
  logic [31:0]   mcb_dat;
  logic          req;
  logic [AB-1:0] adr;
  logic          valid;
  logic [AX-1:0] dat;
  logic [DL:0]   level;
  logic [1:0]    err;
  logic [1:0]    state;

  assign mcb_ack = r_ack | inj_ack;
  assign mcb_dat = inj_ack ? 32'hFFDEAD00 : r_dat;

  raw_stream_prefetch dut (
    .clock_i(clk), .reset_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .wr_adr_i(wr_adr), .mcb_rdy_i(rdy), .mcb_req_o(req), .mcb_adr_o(adr),
    .mcb_ack_i(mcb_ack), .mcb_dat_i(mcb_dat), .pop_i(pop), .valid_o(valid),
    .dat_o(dat), .level_o(level), .err_o(err), .state_o(state)
  );

  // ---------------- wrap instance (ABITS=4) ----------------
  logic         w_rst_n = 1'b0;
  logic         w_en = 1'b0;
  logic         w_rdy = 1'b0;
  logic [3:0]   w_wr = '0;
  logic         w_ack = 1'b0;
  logic [31:0]  w_dati = '0;
  logic         w_pop = 1'b0;
  logic         w_req;
  logic [3:0]   w_adr;
  logic         w_valid;
  logic [AX-1:0] w_dat;
  logic [DL:0]  w_level;
  logic [1:0]   w_err;
  logic [1:0]   w_state;

  raw_stream_prefetch #(.ABITS(4)) dut_w (
    .clock_i(clk), .reset_ni(w_rst_n), .enable_i(w_en), .clear_i(1'b0),
    .wr_adr_i(w_wr), .mcb_rdy_i(w_rdy), .mcb_req_o(w_req), .mcb_adr_o(w_adr),
    .mcb_ack_i(w_ack), .mcb_dat_i(w_dati), .pop_i(w_pop), .valid_o(w_valid),
    .dat_o(w_dat), .level_o(w_level), .err_o(w_err), .state_o(w_state)
  );

  // ---------------- MCB responders ----------------
  int            cyc = 0;
  pend_t         pend[$];
  logic [AB-1:0] req_log[$];
  int            req_cyc[$];

  always @(negedge clk) begin
    cyc++;
    r_ack = 1'b0;
    if (!rst_n) begin
      pend.delete();
    end else begin
      if (req) begin
        pend.push_back('{due: cyc + 3, d: 32'hA5000000 | 32'(adr)});
        req_log.push_back(adr);
        req_cyc.push_back(cyc);
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r_ack = 1'b1;
        r_dat = pend[0].d;
        void'(pend.pop_front());
      end
    end
  end

  int         w_cyc = 0;
  pend_t      w_pend[$];
  logic [3:0] w_log[$];

  always @(negedge clk) begin
    w_cyc++;
    w_ack = 1'b0;
    if (!w_rst_n) begin
      w_pend.delete();
    end else begin
      if (w_req) begin
        w_pend.push_back('{due: w_cyc + 3, d: 32'(w_adr)});
        w_log.push_back(w_adr);
      end
      if (w_pend.size() > 0 && w_pend[0].due == w_cyc) begin
        w_ack = 1'b1;
        w_dati = w_pend[0].d;
        void'(w_pend.pop_front());
      end
    end
    w_pop = w_valid && w_rst_n;
  end

  // ---------------- behavioural model of the main instance ----------------
  int            m_state = 0;
  int            m_out = 0;
  logic [AB-1:0] m_rd = '0;
  logic [AB-1:0] m_adr = '0;
  bit            m_req = 1'b0;
  bit [1:0]      m_err = 2'b00;
  logic [AX-1:0] m_q[$];
  int            o0, l0, s0;
  bit            b_issue, b_under, b_stray;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_out = 0; m_rd = '0; m_adr = '0; m_req = 1'b0; m_err = 2'b00;
      m_q.delete();
    end else begin
      o0 = m_out; l0 = m_q.size(); s0 = m_state;
      b_issue = (s0 == 1) && enable && rdy && (l0 + o0 < DEPTH) && (m_rd != wr_adr);
      b_under = pop && (l0 == 0);
      b_stray = mcb_ack && (o0 == 0);
      if (pop && l0 > 0) void'(m_q.pop_front());
      if (mcb_ack && o0 > 0) begin
        m_out--;
        if (s0 == 1) m_q.push_back(mcb_dat[AX-1:0]);
      end
      m_req = b_issue;
      if (b_issue) begin
        m_adr = m_rd;
        m_rd = m_rd + 1'b1;
        m_out++;
      end
      m_err[0] = b_under | (m_err[0] & ~clear);
      m_err[1] = b_stray | (m_err[1] & ~clear);
      if (s0 == 0 && enable) m_state = 1;
      else if (s0 == 1 && !enable) m_state = (o0 != 0) ? 2 : 0;
      else if (s0 == 2 && o0 == 0) m_state = 0;
      if (m_state == 0 && s0 != 0) m_q.delete();
    end
  end

  // Compare the DUT against the model every cycle, mid-cycle.
  always @(negedge clk) begin
    chk("req", req, m_req);
    if (m_req) chk("adr", adr, m_adr);
    chk("valid", valid, m_q.size() != 0);
    chk("level", level, m_q.size());
    if (m_q.size() != 0) chk("dat", dat, m_q[0]);
    chk("err", err, m_err);
    chk("state", state, m_state);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pop_one(output logic [AX-1:0] v);
    int t;
    t = 0;
    while (!valid && t < 50) begin
      step();
      t++;
    end
    chk("pop_wait", t < 50, 1'b1);
    v = dat;
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  initial begin
    logic [AX-1:0] v;
    int t;

    // reset state
    step(3);
    chk("rst_level", level, 0);
    chk("rst_valid", valid, 0);
    chk("rst_state", state, 0);
    chk("rst_err", err, 0);
    chk("rst_req", req, 0);
    rst_n = 1'b1;

    // first burst: four back-to-back requests fill the credit
    wr_adr = 100; rdy = 1'b1; enable = 1'b1;
    step(15);
    chk("burst_n", req_log.size(), 4);
    for (int i = 0; i < req_log.size() && i < 4; i++) chk("burst_adr", req_log[i], i);
    if (req_cyc.size() >= 4) chk("burst_consec", req_cyc[3] - req_cyc[0], 3);
    chk("burst_level", level, 4);
    chk("burst_valid", valid, 1);
    chk("burst_head", dat, 0);

    // pop stream: 20 pops, one every third cycle
    for (int i = 0; i < 20; i++) begin
      pop_one(v);
      chk("stream_dat", v, i);
      step(2);
    end
    step(20);
    chk("stream_reqs", req_log.size(), 24);
    chk("stream_err", err, 0);

    // catch-up against the write pointer, from a fresh reset
    enable = 1'b0;
    step(10);
    @(negedge clk);
    #3 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    req_log.delete(); req_cyc.delete();
    wr_adr = 2; enable = 1'b1;
    step(15);
    chk("catch_n", req_log.size(), 2);
    for (int i = 0; i < req_log.size() && i < 2; i++) chk("catch_adr", req_log[i], i);
    chk("catch_level", level, 2);
    wr_adr = 5;
    for (int i = 0; i < 3; i++) begin
      pop_one(v);
      chk("catch_pop", v, i);
    end
    step(15);
    chk("catch_n2", req_log.size(), 5);
    for (int i = 2; i < req_log.size() && i < 5; i++) chk("catch_adr2", req_log[i], i);

    // disable with two reads in flight
    for (int k = 0; k < 8 && valid; k++) begin
      pop_one(v);
      chk("empty_dat", v, 3 + k);
    end
    wr_adr = 7;
    t = 0;
    while (req_log.size() < 7 && t < 30) begin
      step();
      t++;
    end
    chk("mid_reqs", req_log.size(), 7);
    enable = 1'b0;
    step();
    chk("drain_state", state, 2);
    step();
    chk("drain_state2", state, 2);
    chk("drain_level", level, 0);
    t = 0;
    while (state != 0 && t < 20) begin
      step();
      t++;
    end
    chk("drain_done", state, 0);
    chk("drain_lvl0", level, 0);
    chk("drain_val0", valid, 0);

    // sticky errors and clear
    step(4);
    chk("err_none", err, 2'b00);
    pop = 1'b1; step(); pop = 1'b0; step();
    chk("err_under", err, 2'b01);
    inj_ack = 1'b1; step(); inj_ack = 1'b0; step();
    chk("err_stray", err, 2'b11);
    clear = 1'b1; step(); clear = 1'b0; step();
    chk("err_clear", err, 2'b00);
    clear = 1'b1; pop = 1'b1; step(); clear = 1'b0; pop = 1'b0; step();
    chk("err_clr_pri", err, 2'b01);

    // address wrap on a 4-bit instance
    w_rst_n = 1'b1; w_rdy = 1'b1; w_wr = 14; w_en = 1'b1;
    t = 0;
    while (w_log.size() < 14 && t < 200) begin
      step();
      t++;
    end
    chk("w_prefill", w_log.size(), 14);
    step(10);
    w_log.delete();
    w_wr = 3;
    step(30);
    chk("w_n", w_log.size(), 5);
    if (w_log.size() == 5) begin
      chk("w_a0", w_log[0], 14);
      chk("w_a1", w_log[1], 15);
      chk("w_a2", w_log[2], 0);
      chk("w_a3", w_log[3], 1);
      chk("w_a4", w_log[4], 2);
    end
    chk("w_err", w_err, 0);

    // asynchronous reset in the middle of a run
    w_wr = 13;
    step(3);
    chk("w_running", w_state, 1);
    @(posedge clk);
    #1 w_rst_n = 1'b0;
    #1;
    chk("w_ar_state", w_state, 0);
    chk("w_ar_req", w_req, 0);
    chk("w_ar_adr", w_adr, 0);
    chk("w_ar_valid", w_valid, 0);
    chk("w_ar_level", w_level, 0);
    chk("w_ar_dat", w_dat, 0);
    chk("w_ar_err", w_err, 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/raw_stream_prefetch.md
Name: raw_stream_prefetch

Overview:
- Read-side prefetch buffer between the Memory Controller Block (MCB) and the raw-data streaming register of the acquisition unit.
- Generates sequential DRAM read requests behind the capture write pointer, and holds returned 24-bit antenna words in a small first-word-fall-through (FWFT) FIFO.
- Presents the head word to the byte-streaming logic, which pops one word per three bytes sent.
- Flags underruns and unsolicited MCB acknowledges so the system register can report them.

Parameters:
AXNUM, 24, antenna word width (bits of mcb_dat_i used, LSB-aligned)
ABITS, 21, MCB word-address width
DLOG, 2, log2 of FIFO depth (DEPTH = 2**DLOG = 4)
DELAY, 3, simulation-only register delay

Ports:
clock_i  in  1  system/Wishbone clock; sole clock
reset_ni  in  1  asynchronous, active-low reset
enable_i  in  1  streaming enabled (raw buffer filled); low = stop and flush
clear_i  in  1  pulse: clear sticky error flags
wr_adr_i  in  ABITS  capture write pointer (next address to be written)
mcb_rdy_i  in  1  MCB accepts commands
mcb_req_o  out  1  one-cycle read-request strobe
mcb_adr_o  out  ABITS  read address, valid while mcb_req_o high
mcb_ack_i  in  1  read data valid (one per request, in order)
mcb_dat_i  in  32  read data
pop_i  in  1  consumer has finished with the head word
valid_o  out  1  FIFO non-empty
dat_o  out  AXNUM  head word (FWFT)
level_o  out  DLOG+1  words held
err_o  out  2  sticky: [0] underrun, [1] unsolicited ack
state_o  out  2  FSM state

Behaviour:
- Reset (reset_ni low, asynchronous): every output is 0, FIFO is empty, rd_adr = 0, outstanding = 0, state = IDLE.
- FSM encoding: IDLE=0, RUN=1, DRAIN=2.
- IDLE -> RUN when enable_i = 1.
- RUN -> DRAIN when enable_i = 0 and outstanding != 0. RUN -> IDLE when enable_i = 0 and outstanding = 0.
- DRAIN -> IDLE when outstanding = 0. Acks arriving in DRAIN decrement outstanding and their data is discarded.
- Entering IDLE: FIFO is flushed (level 0, valid_o 0). rd_adr is retained; a new RUN continues sequentially.
- Credit rule: a request is issued when state = RUN, mcb_rdy_i = 1, level + outstanding < DEPTH, and rd_adr != wr_adr_i.
- Request timing: the condition is evaluated at cycle n. mcb_req_o is high for exactly cycle n+1, with mcb_adr_o = rd_adr. rd_adr increments and outstanding increments at the same edge, so at most one request issues per cycle.
- rd_adr wraps from 2**ABITS-1 to 0. outstanding is DLOG+1 bits wide.
- Ack handling: mcb_ack_i in RUN with outstanding > 0 writes mcb_dat_i[AXNUM-1:0] into the FIFO and decrements outstanding.
- Ack latency: if the FIFO was empty, valid_o and dat_o update on the next edge (1-cycle latency).
- Unsolicited ack: mcb_ack_i with outstanding = 0, in any state, is ignored and sets err_o[1].
- Pop: pop_i with valid_o = 1 removes the head word. The next word appears on dat_o the following cycle.
- Underrun: pop_i with valid_o = 0 is ignored and sets err_o[0].
- Simultaneous ack and pop: level is unchanged, the head advances, and the new word is written.
- Simultaneous request issue and ack: outstanding is unchanged.
- Full FIFO: overflow is impossible under the credit rule. Checking builds assert on an ack while level = DEPTH.
- clear_i zeroes err_o on the next edge. A new error event in the same cycle as clear_i takes priority, and the flag stays set.
- Pointer wrap: the FIFO read/write pointers are DLOG bits and wrap naturally.
- Reset during DRAIN: everything returns to its reset values. Any ack arriving after reset counts as unsolicited.

Test Plan:
- Reset then enable: set wr_adr_i=100, mcb_rdy_i=1, acks 3 cycles after each request. Expect requests at adr 0,1,2,3 on consecutive cycles, then none until a pop; level_o=4 and valid_o=1.
- Pop stream: pop every 3rd cycle for 20 pops with data = address. dat_o must show 0..19 in order, with err_o=0 and exactly 24 requests issued in total.
- Catch-up: wr_adr_i=2. Expect only addresses 0 and 1 to be requested. Then set wr_adr_i=5 and expect 2,3,4 to follow.
- Disable mid-flight: drop enable_i with 2 requests outstanding. Expect state 2 until both acks arrive, then state 0 with level_o=0 and valid_o=0, and no data latched.
- Errors: pop_i with an empty FIFO gives err_o=01. An ack in IDLE gives err_o=11. clear_i returns 00; clear_i coincident with an underrun leaves 01.
- Wrap: ABITS=4 with rd_adr starting at 14 and wr_adr_i=3. Requests go 14,15,0,1,2 then stop. Asserting reset_ni low mid-run zeros all outputs asynchronously.
